byte_transmitter: RTL and testbench

- Serializer that shifts a parallel word out one bit per clock, LSB first by default, on a single-bit output.
- Asserts a sticky done flag when the last bit has been presented.
- Used inside the JTAG TAP to drive the IDCODE register onto TDO during Shift-DR.
- Clocked on the JTAG TCK.

---
 rtl/byte_transmitter.sv | 54 +++++
 tb/tb_byte_transmitter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/byte_transmitter.sv
// Registered serializer: shifts a WIDTH-bit word out one bit per enabled TCK edge with a sticky done flag.
// Define BYTE_TRANSMITTER_MSB_FIRST_EN to send in[WIDTH-1] first; the default order is LSB first.
module byte_transmitter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_tck,
  input  logic             trst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] in,
  output logic             out,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int IW = $clog2(WIDTH);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] ordered;
  logic             sel_bit;
  logic             word_end;
  logic             last_bit;

`ifdef BYTE_TRANSMITTER_MSB_FIRST_EN
  // Reverse the word once so the counter always walks the index upward.
  for (genvar g = 0; g < WIDTH; g++) begin : g_rev
    assign ordered[g] = in[WIDTH-1-g];
  end
`else
  assign ordered = in;
`endif

  always_comb begin
    sel_bit  = ordered[cnt[IW-1:0]];
    word_end = (cnt == CW'(WIDTH));
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk_tck or negedge trst_n) begin
    if (!trst_n) begin
      cnt  <= '0;
      out  <= 1'b0;
      done <= 1'b0;
    end else if (enable) begin
      if (!word_end) begin
        out  <= sel_bit;
        cnt  <= cnt + CW'(1);
        done <= last_bit;
      end else begin
        out  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_byte_transmitter.sv
// Scoreboard bench for byte_transmitter: a bench-side reference model pushes {out,done} per edge and the checker pops it.
module tb_byte_transmitter;

  localparam int WIDTH = 32;

  logic             clk_tck = 1'b0;
  logic             trst_n  = 1'b0;
  logic             enable  = 1'b0;
  logic [WIDTH-1:0] in      = '0;
  logic             out;
  logic             done;

  int errors = 0;
  int checks = 0;

  logic [1:0] exp_q[$];
  int         m_cnt;
  logic       m_out;
  logic       m_done;
  int         sent;
  int         first_done;

  byte_transmitter #(.WIDTH(WIDTH)) dut (
    .clk_tck(clk_tck),
    .trst_n (trst_n),
    .enable (enable),
    .in     (in),
    .out    (out),
    .done   (done)
  );

  always #5 clk_tck = ~clk_tck;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic bit_of(input logic [WIDTH-1:0] w, input int k);
`ifdef BYTE_TRANSMITTER_MSB_FIRST_EN
    return w[WIDTH-1-k];
`else
    return w[k];
`endif
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_out = 1'b0; m_done = 1'b0; sent = 0;
  endtask

  // One clock: predict, push, clock, pop and compare.
  task automatic step(input logic en, input string tag);
    logic [1:0] e;
    enable = en;
    if (en) begin
      if (m_cnt < WIDTH) begin
        m_out  = bit_of(in, m_cnt);
        m_done = (m_cnt == WIDTH - 1);
        m_cnt++;
      end else begin
        m_out = 1'b0;
      end
    end
    exp_q.push_back({m_out, m_done});
    @(posedge clk_tck);
    #1;
    e = exp_q.pop_front();
    check_eq({tag, ".out"},  {63'd0, out},  {63'd0, e[1]});
    check_eq({tag, ".done"}, {63'd0, done}, {63'd0, e[0]});
    if (en) sent++;
  endtask

  task automatic do_reset();
    @(negedge clk_tck);
    trst_n = 1'b0;
    #1;
    check_eq("rst_async.out",  {63'd0, out},  64'd0);
    check_eq("rst_async.done", {63'd0, done}, 64'd0);
    @(negedge clk_tck);
    trst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [19:0] pat;
    // Test 1: reset held across edges with enable high
    in = 32'h000FAF01;
    enable = 1'b1;
    trst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_tck);
      #1;
      check_eq("rst_hold.out",  {63'd0, out},  64'd0);
      check_eq("rst_hold.done", {63'd0, done}, 64'd0);
    end
    @(negedge clk_tck);
    trst_n = 1'b1;
    model_reset();

    // Test 2: full word, plus literal check of the documented LSB-first pattern
    pat = 20'b11111010111100000001;
    for (int k = 0; k < WIDTH; k++) begin
      step(1'b1, "word");
`ifndef BYTE_TRANSMITTER_MSB_FIRST_EN
      check_eq("word.pattern", {63'd0, out}, {63'd0, (k < 20) ? pat[k] : 1'b0});
`endif
      check_eq("word.done_edge", {63'd0, done}, {63'd0, (k == WIDTH - 1)});
    end

    // Test 3: post-completion
    for (int k = 0; k < 3; k++) begin
      step(1'b1, "post");
      check_eq("post.out",  {63'd0, out},  64'd0);
      check_eq("post.done", {63'd0, done}, 64'd1);
    end

    // Test 4: pause mid-word; out holds at 1, done after 36th total edge
    do_reset();
    in = '1;
    first_done = -1;
    for (int t = 1; t <= 36; t++) begin
      step((t <= 5 || t > 9), "pause");
      if (t > 5 && t <= 9) check_eq("pause.frozen", {63'd0, out}, 64'd1);
      if (done && first_done < 0) first_done = t;
    end
    check_eq("pause.done_at", first_done, 36);

    // Test 5: async reset mid-word, then full restart
    in = 32'hA5A5A5A5;
    do_reset();
    for (int k = 0; k < 10; k++) step(1'b1, "mid");
    do_reset();
    first_done = -1;
    for (int k = 0; k < WIDTH + 1; k++) begin
      step(1'b1, "restart");
      if (k == 0) check_eq("restart.first", {63'd0, out}, {63'd0, bit_of(in, 0)});
      if (done && first_done < 0) first_done = k + 1;
    end
    check_eq("restart.done_at", first_done, WIDTH);

`ifdef BYTE_TRANSMITTER_MSB_FIRST_EN
    // Test 6: MSB-first ordering with an endpoint-marked word
    in = 32'h80000001;
    do_reset();
    for (int k = 0; k < WIDTH; k++) begin
      step(1'b1, "msb");
      check_eq("msb.literal", {63'd0, out}, {63'd0, (k == 0 || k == WIDTH - 1)});
    end
    check_eq("msb.done", {63'd0, done}, 64'd1);
`endif

    check_eq("sb.empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
